// File: rtl/axi4l_ipif_bridge.sv
// AXI4-Lite slave to IPIF-style register bus bridge, one outstanding transaction.
// Optional macro AXI4L_IPIF_ERR_EN adds ip2bus_error and SLVERR responses.
module axi4l_ipif_bridge #(
    parameter int unsigned C_ADDR_WIDTH = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [31:0]             s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [31:0]             s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [C_ADDR_WIDTH-1:0] bus2ip_addr,
    output logic [31:0]             bus2ip_data,
    output logic [3:0]              bus2ip_be,
    output logic                    bus2ip_wrce,
    output logic                    bus2ip_rdce,
`ifdef AXI4L_IPIF_ERR_EN
    input  logic                    ip2bus_error,
`endif
    input  logic [31:0]             ip2bus_data
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_STB  = 3'd1,
        WR_RESP = 3'd2,
        RD_STB  = 3'd3,
        RD_CAP  = 3'd4,
        RD_RESP = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    aw_got_q, aw_got_d;
    logic                    w_got_q, w_got_d;
    logic                    last_was_write_q, last_was_write_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [1:0]              rresp_q, rresp_d;

    logic idle_c, rd_sel_c, awready_c, wready_c, arready_c;
    logic aw_hs_c, w_hs_c, ar_hs_c;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[31:C_ADDR_WIDTH], s_axi_araddr[31:C_ADDR_WIDTH]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q          <= IDLE;
            aw_got_q         <= 1'b0;
            w_got_q          <= 1'b0;
            last_was_write_q <= 1'b0;
            addr_q           <= '0;
            data_q           <= '0;
            be_q             <= '0;
            rdata_q          <= '0;
            bresp_q          <= RESP_OKAY;
            rresp_q          <= RESP_OKAY;
        end else begin
            state_q          <= state_d;
            aw_got_q         <= aw_got_d;
            w_got_q          <= w_got_d;
            last_was_write_q <= last_was_write_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            be_q             <= be_d;
            rdata_q          <= rdata_d;
            bresp_q          <= bresp_d;
            rresp_q          <= rresp_d;
        end
    end

    // Read wins a contested IDLE cycle only right after a completed write.
    always_comb begin
        state_d          = state_q;
        aw_got_d         = aw_got_q;
        w_got_d          = w_got_q;
        last_was_write_d = last_was_write_q;
        addr_d           = addr_q;
        data_d           = data_q;
        be_d             = be_q;
        rdata_d          = rdata_q;
        bresp_d          = bresp_q;
        rresp_d          = rresp_q;

        idle_c    = (state_q == IDLE) && !areset;
        rd_sel_c  = idle_c && !aw_got_q && !w_got_q && s_axi_arvalid &&
                    (!(s_axi_awvalid || s_axi_wvalid) || last_was_write_q);
        awready_c = idle_c && !aw_got_q && !rd_sel_c;
        wready_c  = idle_c && !w_got_q && !rd_sel_c;
        arready_c = rd_sel_c;
        aw_hs_c   = s_axi_awvalid && awready_c;
        w_hs_c    = s_axi_wvalid && wready_c;
        ar_hs_c   = s_axi_arvalid && arready_c;

        case (state_q)
            IDLE: begin
                if (aw_hs_c) begin
                    aw_got_d = 1'b1;
                    addr_d   = s_axi_awaddr[C_ADDR_WIDTH-1:0];
                end
                if (w_hs_c) begin
                    w_got_d = 1'b1;
                    data_d  = s_axi_wdata;
                    be_d    = s_axi_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    state_d = WR_STB;
                end else if (ar_hs_c) begin
                    addr_d  = s_axi_araddr[C_ADDR_WIDTH-1:0];
                    state_d = RD_STB;
                end
            end
            WR_STB: begin
`ifdef AXI4L_IPIF_ERR_EN
                bresp_d = ip2bus_error ? RESP_SLVERR : RESP_OKAY;
`else
                bresp_d = RESP_OKAY;
`endif
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    state_d          = IDLE;
                    aw_got_d         = 1'b0;
                    w_got_d          = 1'b0;
                    last_was_write_d = 1'b1;
                end
            end
            RD_STB: state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = ip2bus_data;
`ifdef AXI4L_IPIF_ERR_EN
                rresp_d = ip2bus_error ? RESP_SLVERR : RESP_OKAY;
`else
                rresp_d = RESP_OKAY;
`endif
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    state_d          = IDLE;
                    last_was_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axi_awready = awready_c;
    assign s_axi_wready  = wready_c;
    assign s_axi_arready = arready_c;
    assign s_axi_bvalid  = (state_q == WR_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (state_q == RD_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign bus2ip_addr   = addr_q;
    assign bus2ip_data   = data_q;
    assign bus2ip_be     = be_q;
    assign bus2ip_wrce   = (state_q == WR_STB);
    assign bus2ip_rdce   = (state_q == RD_STB);

endmodule

// File: tb/tb_axi4l_ipif_bridge.sv
// Self-checking bench for axi4l_ipif_bridge: directed cases plus randomized traffic
// against a reference register-file and arbitration model.
module tb_axi4l_ipif_bridge;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [11:0] bus2ip_addr;
    logic [31:0] bus2ip_data;
    logic [3:0]  bus2ip_be;
    logic        bus2ip_wrce;
    logic        bus2ip_rdce;
    logic [31:0] ip2bus_data = '0;

    bit [31:0] ip_regs [4096];
    bit [31:0] ref_mem [4096];
    bit        ref_lww;
    int        checks = 0;
    int        failures = 0;

    always #5 aclk = ~aclk;

    axi4l_ipif_bridge #(.C_ADDR_WIDTH(12)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .bus2ip_addr(bus2ip_addr), .bus2ip_data(bus2ip_data), .bus2ip_be(bus2ip_be),
        .bus2ip_wrce(bus2ip_wrce), .bus2ip_rdce(bus2ip_rdce),
`ifdef AXI4L_IPIF_ERR_EN
        .ip2bus_error(1'b0),
`endif
        .ip2bus_data(ip2bus_data)
    );

    // IP-side register file: byte-enabled writes, read data one cycle after rdce.
    always @(posedge aclk) begin : ip_model
        logic [31:0] nv;
        if (bus2ip_wrce) begin
            nv = ip_regs[bus2ip_addr];
            for (int i = 0; i < 4; i++)
                if (bus2ip_be[i]) nv[8*i +: 8] = bus2ip_data[8*i +: 8];
            ip_regs[bus2ip_addr] <= nv;
        end
        if (bus2ip_rdce) ip2bus_data <= ip_regs[bus2ip_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[a[11:0]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_strobes", 32'({bus2ip_wrce, bus2ip_rdce}), 32'd0);
        chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_bus2ip", 32'(^{bus2ip_addr, bus2ip_data, bus2ip_be} | |{bus2ip_addr, bus2ip_data, bus2ip_be}), 32'd0);
        areset = 1'b0;
        ref_lww = 1'b0;
        @(negedge aclk);
        chk("idle_awready", 32'(s_axi_awready), 32'd1);
        chk("idle_wready", 32'(s_axi_wready), 32'd1);
        chk("idle_arready", 32'(s_axi_arready), 32'd0);
    endtask

    // Drives an optional write and/or read with per-channel start delays and
    // response-ready delays; checks strobes, latency, responses and arbitration.
    task automatic xact(input bit do_wr, input bit do_rd,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                        input int aw_dly, input int w_dly,
                        input logic [31:0] ra, input int ar_dly,
                        input int b_dly, input int r_dly);
        bit aw_done = !do_wr, w_done = !do_wr, ar_done = !do_rd;
        bit b_done = !do_wr, r_done = !do_rd;
        bit aw_f, w_f, ar_f, b_f, r_f;
        int wr_hs_k = -1, ar_hs_k = -1, wrce_k = -1, rdce_k = -1, bv_k = -1, rv_k = -1;
        int wrce_n = 0, rdce_n = 0;
        logic [31:0] exp_rd = '0;
        bit concurrent = do_wr && do_rd && aw_dly == 0 && w_dly == 0 && ar_dly == 0;
        bit exp_read_first = ref_lww;
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            if (bus2ip_wrce) begin
                wrce_n++; wrce_k = k;
                chk("wr_addr", 32'(bus2ip_addr), 32'(wa[11:0]));
                chk("wr_data", bus2ip_data, wd);
                chk("wr_be", 32'(bus2ip_be), 32'(wbe));
            end
            if (bus2ip_rdce) begin
                rdce_n++; rdce_k = k;
                chk("rd_addr", 32'(bus2ip_addr), 32'(ra[11:0]));
            end
            if (s_axi_bvalid && bv_k < 0) begin
                bv_k = k;
                chk("bresp", 32'(s_axi_bresp), 32'd0);
                chk("b_latency", 32'(k - wr_hs_k), 32'd2);
            end
            if (s_axi_rvalid) begin
                if (rv_k < 0) begin
                    rv_k = k;
                    chk("rresp", 32'(s_axi_rresp), 32'd0);
                    chk("r_latency", 32'(k - ar_hs_k), 32'd3);
                end
                chk("rdata", s_axi_rdata, exp_rd);
            end
            if (do_wr && (aw_done || w_done) && !b_done)
                chk("arready_blocked", 32'(s_axi_arready), 32'd0);

            s_axi_awaddr  = wa; s_axi_wdata = wd; s_axi_wstrb = wbe; s_axi_araddr = ra;
            s_axi_awprot  = 3'($urandom); s_axi_arprot = 3'($urandom);
            s_axi_awvalid = !aw_done && k >= aw_dly;
            s_axi_wvalid  = !w_done && k >= w_dly;
            s_axi_arvalid = !ar_done && k >= ar_dly;
            s_axi_bready  = !b_done && (b_dly == 0 || (bv_k >= 0 && k - bv_k >= b_dly));
            s_axi_rready  = !r_done && (r_dly == 0 || (rv_k >= 0 && k - rv_k >= r_dly));
            #1;
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            ar_f = s_axi_arvalid && s_axi_arready;
            b_f  = s_axi_bvalid && s_axi_bready;
            r_f  = s_axi_rvalid && s_axi_rready;
            @(posedge aclk);
            if (aw_f) aw_done = 1'b1;
            if (w_f) w_done = 1'b1;
            if ((aw_f || w_f) && aw_done && w_done) begin
                wr_hs_k = k;
                ref_write(wa, wd, wbe);
            end
            if (ar_f) begin
                ar_done = 1'b1; ar_hs_k = k;
                exp_rd = ref_mem[ra[11:0]];
            end
            if (b_f) begin b_done = 1'b1; ref_lww = 1'b1; end
            if (r_f) begin r_done = 1'b1; ref_lww = 1'b0; end
            if (b_done && r_done) break;
        end
        chk("xact_done", 32'(b_done && r_done), 32'd1);
        if (do_wr) begin
            chk("wrce_pulses", 32'(wrce_n), 32'd1);
            chk("wrce_latency", 32'(wrce_k - wr_hs_k), 32'd1);
        end
        if (do_rd) begin
            chk("rdce_pulses", 32'(rdce_n), 32'd1);
            chk("rdce_latency", 32'(rdce_k - ar_hs_k), 32'd1);
        end
        if (concurrent)
            chk("arb_read_first", 32'(ar_hs_k >= 0 && ar_hs_k < wr_hs_k), 32'(exp_read_first));
        @(negedge aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, wa, wd;
        logic [3:0]  wbe;
        int          kind;

        do_reset();

        // Same-cycle AW/W
        xact(1, 0, 32'h4, 32'hABCDEF01, 4'hF, 0, 0, 32'h0, 0, 0, 0);
        // AW before W with a read waiting behind the partial write
        xact(1, 1, 32'h10, 32'h5555AAAA, 4'hF, 0, 1, 32'h10, 1, 0, 0);
        // W three cycles before AW, partial strobes
        xact(1, 0, 32'h20, 32'hCAFEF00D, 4'h5, 3, 0, 32'h0, 0, 0, 0);
        // Read with stalled rready
        xact(1, 0, 32'h8, 32'h12345678, 4'hF, 0, 0, 32'h0, 0, 0, 0);
        xact(0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 32'h8, 0, 0, 5);
        // Back-pressured write response
        xact(1, 0, 32'h24, 32'h0BADBEEF, 4'hA, 1, 1, 32'h0, 0, 4, 0);

        // Arbitration from reset, then after a completed write
        do_reset();
        xact(1, 1, 32'h30, 32'h11112222, 4'hF, 0, 0, 32'h8, 0, 0, 0);
        xact(1, 0, 32'h34, 32'h33334444, 4'hF, 0, 0, 32'h0, 0, 0, 0);
        xact(1, 1, 32'h38, 32'h55556666, 4'hF, 0, 0, 32'h34, 0, 0, 0);

        // Reset asserted while the read is in RD_CAP
        @(negedge aclk);
        s_axi_araddr = 32'h8; s_axi_arvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrd_rdce_seen", 32'(bus2ip_rdce), 32'd1);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("midrd_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("midrd_rdce", 32'(bus2ip_rdce), 32'd0);
        chk("midrd_arready", 32'(s_axi_arready), 32'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        s_axi_arvalid = 1'b0; areset = 1'b0; ref_lww = 1'b0;
        repeat (3) @(negedge aclk);
        chk("post_rst_quiet", 32'({bus2ip_rdce, bus2ip_wrce, s_axi_rvalid, s_axi_bvalid}), 32'd0);
        xact(0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 32'h8, 0, 0, 0);

        // Randomized traffic over a small address window
        for (int n = 0; n < 24; n++) begin
            wa   = {20'd0, 6'($urandom_range(0, 15)), 2'b00};
            ra   = {20'd0, 6'($urandom_range(0, 15)), 2'b00};
            wd   = $urandom;
            wbe  = 4'($urandom_range(0, 15));
            kind = $urandom_range(0, 2);
            xact(kind != 1, kind != 0, wa, wd, wbe,
                 $urandom_range(0, 2), $urandom_range(0, 2), ra, $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
